jk_cmd_driver: RTL and testbench

Command sequencer directly upstream of the JK latch stage. Accepts timed JK commands (hold, clear, set, toggle) over a valid/ready handshake, buffers them in a small FIFO, and drives registered `j`/`k` for each command's programmed duration. Keeps a cycle-accurate reference model of the downstream `q` and a saturating count of `q` transitions, for self-checking benches and status reporting.

---
 rtl/jk_cmd_driver.sv | 173 +++++++++++++++++
 tb/tb_jk_cmd_driver.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_cmd_driver.sv
`default_nettype none
// ============================================================================
// Module   : jk_cmd_driver
// Brief    : Timed JK command sequencer. Buffers {op,len} commands in a small
//            FIFO, drives registered j/k for len+1 cycles per command and
//            tracks a reference model of the downstream latch output q along
//            with a saturating count of its transitions.
// Revision : 1.0 - initial release
// ============================================================================
module jk_cmd_driver #(
    parameter int DEPTH = 4,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             j,
    output logic             k,
    output logic             busy,
    output logic             done,
    output logic             q_model,
    output logic [7:0]       toggle_count
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_ENTRY_W = LEN_W + 2;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    // FIFO storage and pointers; the extra pointer MSB separates full from empty
    logic [c_ENTRY_W-1:0] r_mem [DEPTH];
    logic [c_ADDR_W:0]    r_wr_ptr;
    logic [c_ADDR_W:0]    r_rd_ptr;

    state_t               r_state;
    logic [LEN_W-1:0]     r_cnt;
    logic                 r_j;
    logic                 r_k;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_q;
    logic [7:0]           r_toggle_cnt;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [c_ENTRY_W-1:0] w_head;
    logic [1:0]           w_head_op;
    logic [LEN_W-1:0]     w_head_len;
    logic                 w_q_next;

    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                        (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);
    // A full FIFO refuses a push even if the same edge pops an entry
    assign w_push     = cmd_valid && !w_full;
    // Pop when idle, or on the final drive cycle so the next command follows without a bubble
    assign w_pop      = !w_empty && ((r_state == ST_IDLE) || (r_cnt == '0));
    assign w_head     = r_mem[r_rd_ptr[c_ADDR_W-1:0]];
    assign w_head_op  = w_head[c_ENTRY_W-1:LEN_W];
    assign w_head_len = w_head[LEN_W-1:0];

    // Command storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= {cmd_op, cmd_len};
        end
    end

    // FIFO pointer bookkeeping, wrapping modulo 2*DEPTH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Sequencer: loads j/k and the duration counter, pulses done on the last cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_j     <= 1'b0;
            r_k     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_state <= ST_DRIVE;
                        r_busy  <= 1'b1;
                        r_j     <= w_head_op[1];
                        r_k     <= w_head_op[0];
                        r_cnt   <= w_head_len;
                        r_done  <= (w_head_len == '0);
                    end
                end
                ST_DRIVE: begin
                    if (r_cnt != '0) begin
                        r_cnt  <= r_cnt - LEN_W'(1);
                        r_done <= (r_cnt == LEN_W'(1));
                    end else if (!w_empty) begin
                        r_j    <= w_head_op[1];
                        r_k    <= w_head_op[0];
                        r_cnt  <= w_head_len;
                        r_done <= (w_head_len == '0);
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_j     <= 1'b0;
                        r_k     <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_j     <= 1'b0;
                    r_k     <= 1'b0;
                end
            endcase
        end
    end

    // Next latch output from the j/k currently presented downstream
    always_comb begin
        w_q_next = r_q;
        case ({r_j, r_k})
            2'b01:   w_q_next = 1'b0;
            2'b10:   w_q_next = 1'b1;
            2'b11:   w_q_next = ~r_q;
            default: w_q_next = r_q;
        endcase
    end

    // Latch reference model and saturating transition counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q          <= 1'b0;
            r_toggle_cnt <= 8'd0;
        end else begin
            r_q <= w_q_next;
            if ((w_q_next != r_q) && (r_toggle_cnt != 8'hFF)) begin
                r_toggle_cnt <= r_toggle_cnt + 8'd1;
            end
        end
    end

    assign cmd_ready    = !w_full;
    assign j            = r_j;
    assign k            = r_k;
    assign busy         = r_busy;
    assign done         = r_done;
    assign q_model      = r_q;
    assign toggle_count = r_toggle_cnt;

endmodule
`default_nettype wire

// File: tb/tb_jk_cmd_driver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_jk_cmd_driver
// Brief    : Bench for jk_cmd_driver. A queue-based reference model predicts
//            every output each cycle; a scoreboard pairs each done pulse with
//            the accepted command it finishes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jk_cmd_driver;

    localparam int DEPTH = 4;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             j;
    logic             k;
    logic             busy;
    logic             done;
    logic             q_model;
    logic [7:0]       toggle_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]       op;
        logic [LEN_W-1:0] len;
    } cmd_t;

    // Reference model: pending queue, active command and remaining cycles
    cmd_t m_fifo[$];
    cmd_t sb_q[$];
    bit         m_act = 1'b0;
    logic [1:0] m_op = 2'b00;
    int         m_rem = 0;
    bit         m_q = 1'b0;
    int         m_tc = 0;
    int         run_len = 0;
    bit         track_ready = 1'b0;
    bit         saw_not_ready = 1'b0;

    cmd_t       mon_c;
    cmd_t       mon_e;
    logic [1:0] mon_jk;
    bit         mon_nq;
    bit         mon_push;

    jk_cmd_driver #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_len      (cmd_len),
        .j            (j),
        .k            (k),
        .busy         (busy),
        .done         (done),
        .q_model      (q_model),
        .toggle_count (toggle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare against the model, score done pulses, then advance the model
    always @(negedge clk) begin
        if (!reset) begin
            m_fifo.delete();
            sb_q.delete();
            m_act = 1'b0; m_op = 2'b00; m_rem = 0; m_q = 1'b0; m_tc = 0; run_len = 0;
            chk("rst_j", j, 0);
            chk("rst_k", k, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_q", q_model, 0);
            chk("rst_tc", toggle_count, 0);
            chk("rst_ready", cmd_ready, 1);
        end else begin
            chk("j", j, m_act ? m_op[1] : 0);
            chk("k", k, m_act ? m_op[0] : 0);
            chk("busy", busy, m_act);
            chk("done", done, (m_act && m_rem == 0) ? 1 : 0);
            chk("q_model", q_model, m_q);
            chk("toggle_count", toggle_count, m_tc);
            chk("cmd_ready", cmd_ready, (m_fifo.size() < DEPTH) ? 1 : 0);

            if (busy) run_len++;
            else      run_len = 0;
            if (done) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_done", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("sb_j", j, mon_e.op[1]);
                    chk("sb_k", k, mon_e.op[0]);
                    chk("sb_duration", run_len, mon_e.len + 1);
                end
                run_len = 0;
            end
            if (track_ready && !cmd_ready) saw_not_ready = 1'b1;

            // Advance the model across the coming rising edge
            mon_jk = m_act ? m_op : 2'b00;
            case (mon_jk)
                2'b01:   mon_nq = 1'b0;
                2'b10:   mon_nq = 1'b1;
                2'b11:   mon_nq = ~m_q;
                default: mon_nq = m_q;
            endcase
            if (mon_nq != m_q && m_tc < 255) m_tc++;
            m_q = mon_nq;

            mon_push = cmd_valid && (m_fifo.size() < DEPTH);
            if (m_act && m_rem > 0) begin
                m_rem--;
            end else if (m_fifo.size() > 0) begin
                mon_c = m_fifo.pop_front();
                m_act = 1'b1; m_op = mon_c.op; m_rem = int'(mon_c.len);
            end else begin
                m_act = 1'b0;
            end
            if (mon_push) begin
                mon_c.op  = cmd_op;
                mon_c.len = cmd_len;
                m_fifo.push_back(mon_c);
                sb_q.push_back(mon_c);
            end
        end
    end

    // Present one command and hold it until accepted; returns 1ns after the accepting edge
    task automatic send(input logic [1:0] op, input logic [LEN_W-1:0] len);
        bit ok = 1'b0;
        cmd_valid = 1'b1; cmd_op = op; cmd_len = len;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drained();
        bit ok = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            @(posedge clk); #1;
            if (!m_act && m_fifo.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) chk("drain_timeout", 0, 1);
        idle(2);
    endtask

    initial begin
        // Reset held with a command presented: nothing may be queued
        reset = 1'b0; cmd_valid = 1'b1; cmd_op = 2'b11; cmd_len = 4'd3;
        repeat (3) @(posedge clk);
        #1;
        cmd_valid = 1'b0; reset = 1'b1;
        #1;
        chk("release_ready", cmd_ready, 1);
        chk("release_busy", busy, 0);

        // Single set, then clear followed by a toggle run
        send(2'b10, 4'd2);
        wait_drained();
        chk("set_q", q_model, 1);
        send(2'b01, 4'd0);
        send(2'b11, 4'd3);
        wait_drained();
        chk("toggle_tc", toggle_count, 6);
        chk("toggle_q", q_model, 0);

        // Long hold keeps the FIFO from draining so it fills behind it
        track_ready = 1'b1;
        send(2'b00, 4'd7);
        send(2'b10, 4'd0);
        send(2'b01, 4'd0);
        send(2'b00, 4'd1);
        send(2'b11, 4'd0);
        send(2'b10, 4'd0);
        wait_drained();
        track_ready = 1'b0;
        chk("full_seen", saw_not_ready, 1);
        chk("b2b_q", q_model, 1);

        // Saturation with repeated pointer wrap
        repeat (17) send(2'b11, 4'd15);
        wait_drained();
        chk("sat_tc", toggle_count, 255);

        // Reset during the third drive cycle of a long set
        send(2'b10, 4'd7);
        @(posedge clk); @(posedge clk); @(posedge clk);
        #1;
        chk("pre_rst_j", j, 1);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_j", j, 0);
        chk("mid_rst_k", k, 0);
        chk("mid_rst_q", q_model, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_tc", toggle_count, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        send(2'b01, 4'd0);
        wait_drained();

        // Randomized traffic, mostly short commands
        for (int i = 0; i < 400; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_len   = LEN_W'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) cmd_len = LEN_W'($urandom_range(0, 15));
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        wait_drained();
        chk("final_sb_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
